// File: rtl/decode_stage_if.sv
// Stage broadcast bundle between the decode sequencer (master) and the array
// consumers (slave): round control inputs plus registered stage/qualifier outputs.
interface decode_stage_if #(
  parameter int NUM_CONTEXTS    = 2,
  parameter int MAX_GROW_ROUNDS = 15,
  parameter int STAGE_WIDTH     = 4
);
  localparam int CTX_W = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;
  localparam int GR_W  = $clog2(MAX_GROW_ROUNDS + 1);

  logic                   start;
  logic                   single_context;
  logic                   busy_in;
  logic                   odd_clusters_in;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   do_not_store;
  logic [CTX_W-1:0]       context_id;
  logic [GR_W-1:0]        grow_rounds;
  logic                   overflow;
  logic                   done;

  modport master (
    input  start, single_context, busy_in, odd_clusters_in,
    output global_stage, do_not_store, context_id, grow_rounds, overflow, done
  );

  modport slave (
    output start, single_context, busy_in, odd_clusters_in,
    input  global_stage, do_not_store, context_id, grow_rounds, overflow, done
  );
endinterface

// File: rtl/decode_stage_controller.sv
// Decode round sequencer: walks each context through load/grow/merge/peel/result/
// memory stages, looping grow/merge while odd clusters remain, then returns to idle.
module decode_stage_controller #(
  parameter int NUM_CONTEXTS    = 2,
  parameter int MERGE_MIN       = 3,
  parameter int RESULT_CYCLES   = 2,
  parameter int MAX_GROW_ROUNDS = 15,
  parameter int STAGE_WIDTH     = 4
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.master ctrl
);
  localparam int CTX_W   = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;
  localparam int GR_W    = $clog2(MAX_GROW_ROUNDS + 1);
  localparam int CNT_MAX = (MERGE_MIN > RESULT_CYCLES) ? MERGE_MIN : RESULT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit ONE_CTX = (NUM_CONTEXTS == 1);

  localparam logic [STAGE_WIDTH-1:0] S_IDLE  = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] S_PARAM = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] S_MEAS  = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] S_GROW  = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] S_MERGE = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] S_PEEL  = STAGE_WIDTH'(5);
  localparam logic [STAGE_WIDTH-1:0] S_RES   = STAGE_WIDTH'(6);
  localparam logic [STAGE_WIDTH-1:0] S_WRITE = STAGE_WIDTH'(7);
  localparam logic [STAGE_WIDTH-1:0] S_READ  = STAGE_WIDTH'(8);

  logic [STAGE_WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CTX_W-1:0]       ctx_q, ctx_d;
  logic [GR_W-1:0]        gr_q, gr_d;
  logic                   dns_q, dns_d;
  logic                   wrap_q, wrap_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic                   params_q, params_d;

  logic merge_exit, regrow, round_end;

  assign merge_exit = (cnt_q >= CNT_W'(MERGE_MIN)) && !ctrl.busy_in;
  assign regrow     = ctrl.odd_clusters_in && (gr_q < GR_W'(MAX_GROW_ROUNDS));
  assign round_end  = dns_q || wrap_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl.start) state_d = params_q ? S_MEAS : S_PARAM;
      S_PARAM: state_d = S_MEAS;
      S_MEAS:  state_d = S_GROW;
      S_GROW:  state_d = S_MERGE;
      S_MERGE: if (merge_exit) state_d = regrow ? S_GROW : S_PEEL;
      S_PEEL:  state_d = S_RES;
      S_RES:   if (cnt_q >= CNT_W'(RESULT_CYCLES)) state_d = S_WRITE;
      S_WRITE: state_d = S_READ;
      S_READ:  state_d = round_end ? S_IDLE : S_MEAS;
      default: state_d = S_IDLE;
    endcase
  end

  // Dwell counter restarts at 1 on every stage change, so it reads the
  // 1-based cycle index within MERGE / RESULT_VALID.
  always_comb begin
    cnt_d    = CNT_W'(1);
    ctx_d    = ctx_q;
    gr_d     = gr_q;
    dns_d    = dns_q;
    wrap_d   = wrap_q;
    ovf_d    = ovf_q;
    params_d = params_q;
    done_d   = 1'b0;
    if (state_d == state_q)
      cnt_d = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: if (ctrl.start) begin
        dns_d    = ctrl.single_context | ONE_CTX;
        ovf_d    = 1'b0;
        ctx_d    = '0;
        wrap_d   = 1'b0;
        params_d = 1'b1;
      end
      S_MEAS:  gr_d = '0;
      S_GROW:  if (gr_q < GR_W'(MAX_GROW_ROUNDS)) gr_d = gr_q + GR_W'(1);
      S_MERGE: if (merge_exit && ctrl.odd_clusters_in && !regrow) ovf_d = 1'b1;
      // The last context's wrap to 0 is recorded in wrap_q and shown on
      // context_id when the round returns to idle.
      S_WRITE: if (!dns_q) begin
        if (ctx_q == CTX_W'(NUM_CONTEXTS - 1)) wrap_d = 1'b1;
        else                                   ctx_d  = ctx_q + CTX_W'(1);
      end
      S_READ: if (round_end) begin
        done_d = 1'b1;
        dns_d  = 1'b0;
        ctx_d  = '0;
        wrap_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      ctx_q    <= '0;
      gr_q     <= '0;
      dns_q    <= 1'b0;
      wrap_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      params_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ctx_q    <= ctx_d;
      gr_q     <= gr_d;
      dns_q    <= dns_d;
      wrap_q   <= wrap_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      params_q <= params_d;
    end
  end

  assign ctrl.global_stage = state_q;
  assign ctrl.do_not_store = dns_q;
  assign ctrl.context_id   = ctx_q;
  assign ctrl.grow_rounds  = gr_q;
  assign ctrl.overflow     = ovf_q;
  assign ctrl.done         = done_q;
endmodule

// File: tb/tb_decode_stage_controller.sv
// Directed bench: each cycle's inputs are driven and the hand-derived expected
// outputs queued; a negedge monitor pops one entry per cycle and compares.
module tb_decode_stage_controller;
  localparam int IDLE = 0, PL = 1, ML = 2, GRW = 3, MG = 4, PE = 5, RV = 6, WR = 7, RD = 8;

  typedef struct {
    int stg; int ctx; int dns; int dn; int gr; int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nmis = 0;
  int   ncyc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  decode_stage_if #(.NUM_CONTEXTS(2), .MAX_GROW_ROUNDS(15), .STAGE_WIDTH(4)) bus ();

  decode_stage_controller #(
    .NUM_CONTEXTS(2), .MERGE_MIN(3), .RESULT_CYCLES(2),
    .MAX_GROW_ROUNDS(15), .STAGE_WIDTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  task automatic chk(input string nm, input int act, input int want);
    nvec++;
    if (act != want) begin
      nmis++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, ncyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.stg >= 0) begin
        chk("global_stage", int'(bus.global_stage), e.stg);
        chk("context_id", int'(bus.context_id), e.ctx);
        chk("do_not_store", int'(bus.do_not_store), e.dns);
        chk("done", int'(bus.done), e.dn);
        if (e.gr >= 0)  chk("grow_rounds", int'(bus.grow_rounds), e.gr);
        if (e.ovf >= 0) chk("overflow", int'(bus.overflow), e.ovf);
      end
    end
  end

  // One clock cycle: drive inputs, queue what the outputs must show this cycle.
  task automatic cyc(input int st, input int sc, input int bsy, input int odd, input int rs,
                     input int stg, input int ctx, input int dns, input int dn,
                     input int gr = -1, input int ovf = -1);
    exp_t e;
    @(posedge clk);
    #1;
    ncyc++;
    bus.start           = st[0];
    bus.single_context  = sc[0];
    bus.busy_in         = bsy[0];
    bus.odd_clusters_in = odd[0];
    reset               = rs[0];
    e.stg = stg; e.ctx = ctx; e.dns = dns; e.dn = dn; e.gr = gr; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // One context with no regrow: ML, GROW, MERGE x3, PEEL, RV x2, WRITE, READ.
  task automatic ctx_seg(input int ctx, input int rctx, input int dns, input int spur = 0);
    cyc(0, 0, 0, 0, 0, ML, ctx, dns, 0);
    cyc(0, 0, 0, 0, 0, GRW, ctx, dns, 0, 0);
    for (int i = 0; i < 3; i++) cyc((i == 1) ? spur : 0, 0, 0, 0, 0, MG, ctx, dns, 0, 1);
    cyc(0, 0, 0, 0, 0, PE, ctx, dns, 0, 1);
    cyc(0, 0, 0, 0, 0, RV, ctx, dns, 0);
    cyc(0, 0, 0, 0, 0, RV, ctx, dns, 0);
    cyc(0, 0, 0, 0, 0, WR, ctx, dns, 0);
    cyc(0, 0, 0, 0, 0, RD, rctx, dns, 0);
  endtask

  // One context with odd clusters stuck high: 15 grow/merge loops then forced exit.
  task automatic ovf_seg(input int ctx, input int rctx, input int ovf0);
    cyc(0, 0, 0, 1, 0, ML, ctx, 0, 0, -1, ovf0);
    for (int k = 1; k <= 15; k++) begin
      cyc(0, 0, 0, 1, 0, GRW, ctx, 0, 0, k - 1, ovf0);
      for (int m = 0; m < 3; m++) cyc(0, 0, 0, 1, 0, MG, ctx, 0, 0, k, ovf0);
    end
    cyc(0, 0, 0, 1, 0, PE, ctx, 0, 0, 15, 1);
    cyc(0, 0, 0, 1, 0, RV, ctx, 0, 0, 15, 1);
    cyc(0, 0, 0, 1, 0, RV, ctx, 0, 0, 15, 1);
    cyc(0, 0, 0, 1, 0, WR, ctx, 0, 0, 15, 1);
    cyc(0, 0, 0, 1, 0, RD, rctx, 0, 0, 15, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.single_context = 1'b0; bus.busy_in = 1'b0; bus.odd_clusters_in = 1'b0;
    cyc(0, 0, 0, 0, 1, -1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, -1, 0, 0, 0);

    // Default two-context round from a fresh reset.
    cyc(1, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, PL, 0, 0, 0);
    ctx_seg(0, 1, 0);
    ctx_seg(1, 1, 0);
    // Start in the done cycle is accepted; params already loaded so no PL.
    cyc(1, 0, 0, 0, 0, IDLE, 0, 0, 1, -1, 0);
    ctx_seg(0, 1, 0, 1);
    ctx_seg(1, 1, 0);
    cyc(0, 0, 0, 0, 0, IDLE, 0, 0, 1);

    // Single-context round.
    cyc(1, 1, 0, 0, 0, IDLE, 0, 0, 0);
    ctx_seg(0, 0, 1);
    cyc(0, 0, 0, 0, 0, IDLE, 0, 0, 1);

    // Reset in idle clears params_loaded; busy held high, one regrow.
    cyc(0, 0, 0, 0, 1, IDLE, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, IDLE, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, PL, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, ML, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, GRW, 0, 0, 0, 0);
    for (int c = 4; c <= 8; c++) cyc(0, 0, 1, 1, 0, MG, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, MG, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, GRW, 0, 0, 0, 1);
    for (int c = 11; c <= 13; c++) cyc(0, 0, 0, 0, 0, MG, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 0, PE, 0, 0, 0, 2, 0);
    cyc(0, 0, 0, 0, 0, RV, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, RV, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, WR, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, RD, 1, 0, 0);
    ctx_seg(1, 1, 0);
    cyc(0, 0, 0, 0, 0, IDLE, 0, 0, 1);

    // Odd clusters stuck: forced exit after 15 grows, overflow sticky to next start.
    cyc(1, 0, 0, 1, 0, IDLE, 0, 0, 0);
    ovf_seg(0, 1, 0);
    ovf_seg(1, 1, 1);
    cyc(0, 0, 0, 1, 0, IDLE, 0, 0, 1, -1, 1);
    cyc(1, 0, 0, 0, 0, IDLE, 0, 0, 0, -1, 1);
    cyc(0, 0, 0, 0, 0, ML, 0, 0, 0, -1, 0);

    // Reset during RESULT_VALID: idle without done, next start reloads params.
    cyc(0, 0, 0, 0, 0, GRW, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, MG, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, PE, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, RV, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, PL, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, ML, 0, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      nmis++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
